tone_period_detector: RTL and testbench

Receive-side counterpart of the speaker tone generator. It samples a square-wave tone input (speaker drive loop-back or microphone comparator output) and measures its period in clk cycles. It declares lock once the period is stable, reports each measured period while locked, and flags loss of tone. It sits beside the speaker block on the same 32 MHz clk domain. Example: 400 Hz tone = 80000-cycle period; 800 Hz = 40000.

---
 rtl/tone_period_detector.sv | 139 +++++++++++++
 tb/tb_tone_period_detector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tone_period_detector.sv
// Measures the period of a square-wave tone in clk cycles, declares lock once
// LOCK_COUNT consecutive periods agree within TOL, and flags loss of tone.
module tone_period_detector #(
  parameter int PERIOD_W   = 20,
  parameter int MIN_PERIOD = 1000,
  parameter int TOL        = 64,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 200000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                tone_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                lost
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] MIN_C     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   TOL_C     = (PERIOD_W+1)'(TOL);
  localparam logic [MW-1:0]       LAST_C    = MW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0]       LOCK_C    = MW'(LOCK_COUNT);

  logic [1:0]          state;
  logic                s1, s2, sd;
  logic [PERIOD_W-1:0] cnt, ref_p;
  logic [MW-1:0]       match_cnt;

  logic                rise, accept, timeout, is_match;
  logic [PERIOD_W:0]   diff;

  // 2-flop synchronizer plus delay flop for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      sd <= s2;
    end
  end

  always_comb begin
    rise    = s2 & ~sd;
    accept  = rise && (cnt >= MIN_C);
    timeout = (cnt == TIMEOUT_C);
    if ({1'b0, cnt} >= {1'b0, ref_p}) diff = {1'b0, cnt} - {1'b0, ref_p};
    else                              diff = {1'b0, ref_p} - {1'b0, cnt};
    is_match = (diff <= TOL_C);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ref_p        <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      lost         <= 1'b0;
      if (!enable) begin
        state     <= S_IDLE;
        locked    <= 1'b0;
        cnt       <= '0;
        ref_p     <= '0;
        match_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_ARM;
          S_ARM: begin
            if (rise) begin
              cnt       <= PERIOD_W'(1);
              match_cnt <= '0;
              state     <= S_MEAS;
            end
          end
          default: begin
            if (timeout) begin
              // a rise coinciding with timeout becomes the fresh first edge
              match_cnt <= '0;
              locked    <= 1'b0;
              if (state == S_LOCK) lost <= 1'b1;
              if (rise) begin
                cnt   <= PERIOD_W'(1);
                state <= S_MEAS;
              end else begin
                cnt   <= '0;
                state <= S_ARM;
              end
            end else if (accept) begin
              cnt <= PERIOD_W'(1);
              if (state == S_LOCK) begin
                if (is_match) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                end else begin
                  lost      <= 1'b1;
                  locked    <= 1'b0;
                  state     <= S_MEAS;
                  ref_p     <= cnt;
                  match_cnt <= MW'(1);
                end
              end else if (match_cnt == '0 || !is_match) begin
                ref_p     <= cnt;
                match_cnt <= MW'(1);
              end else if (match_cnt == LAST_C) begin
                state        <= S_LOCK;
                locked       <= 1'b1;
                period       <= cnt;
                period_valid <= 1'b1;
                match_cnt    <= LOCK_C;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_period_detector.sv
// Table-driven tone stimulus with a scoreboard of expected period_valid/lost
// events, run on a scaled-down parameter set.
module tb_tone_period_detector;

  localparam int PW   = 12;
  localparam int MINP = 20;
  localparam int TOLV = 4;
  localparam int LC   = 4;
  localparam int TO   = 500;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          tone_in = 1'b0;
  logic [PW-1:0] period;
  logic          period_valid, locked, lost;

  tone_period_detector #(
    .PERIOD_W(PW), .MIN_PERIOD(MINP), .TOL(TOLV), .LOCK_COUNT(LC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .tone_in(tone_in),
    .period(period), .period_valid(period_valid), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ev: 0 none, 1 period_valid, 2 lost; p: expected period output at the event
  typedef struct { int len; int ev; int p; bit bounce; } vec_t;
  typedef struct { int ev; int p; int lk; int drv; int lat; } exp_t;

  vec_t vec[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input int len, input int ev, input int p, input bit b);
    vec_t v;
    v.len = len; v.ev = ev; v.p = p; v.bounce = b;
    vec.push_back(v);
  endtask

  task automatic push(input int ev, input int p, input int lat);
    exp_t e;
    if (ev != 0) begin
      e.ev = ev; e.p = p; e.lk = (ev == 1) ? 1 : 0; e.drv = cyc; e.lat = lat;
      sbq.push_back(e);
    end
  endtask

  // each record: a rise, high for len/2, low for the rest; event belongs to that rise
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      push(vec[i].ev, vec[i].p, 3);
      tone_in = 1'b1;
      if (vec[i].bounce) begin
        repeat (5) @(negedge clk);
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        tone_in = 1'b1;
        repeat (vec[i].len / 2 - 8) @(negedge clk);
      end else begin
        repeat (vec[i].len / 2) @(negedge clk);
      end
      tone_in = 1'b0;
      repeat (vec[i].len - vec[i].len / 2) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // lock at 160, switch to 80, bounce, back to 160, tolerance edges
    add(160, 0, 0, 0);   add(160, 0, 0, 0);   add(160, 0, 0, 0);   add(160, 0, 0, 0);
    add(160, 1, 160, 0); add(160, 1, 160, 0); add(160, 1, 160, 0);
    add(80, 1, 160, 0);  add(80, 2, 160, 0);  add(80, 0, 0, 0);    add(80, 0, 0, 0);
    add(80, 1, 80, 0);   add(80, 1, 80, 0);   add(80, 1, 80, 1);
    add(160, 1, 80, 0);  add(160, 2, 80, 0);  add(160, 0, 0, 0);   add(160, 0, 0, 0);
    add(164, 1, 160, 0); add(160, 1, 164, 0); add(164, 1, 160, 0); add(165, 1, 164, 0);
    add(160, 2, 164, 0); add(160, 0, 0, 0);   add(160, 0, 0, 0);   add(160, 0, 0, 0);

    fork
      begin : monitor
        int   k;
        exp_t e;
        forever begin
          @(negedge clk);
          if (resetn && (period_valid || lost)) begin
            k = (period_valid ? 1 : 0) + (lost ? 2 : 0);
            if (sbq.size() == 0) chk("unexpected_event", k, 0);
            else begin
              e = sbq.pop_front();
              chk("event_kind", k, e.ev);
              chk("event_latency", cyc - e.drv, e.lat);
              chk("event_period", int'(period), e.p);
              chk("event_locked", int'(locked), e.lk);
            end
          end
          if (sbq.size() > 0 && cyc - sbq[0].drv > sbq[0].lat) begin
            chk("missed_event", 0, sbq[0].ev);
            void'(sbq.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_period", int'(period), 0);
    chk("reset_valid", int'(period_valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_lost", int'(lost), 0);
    resetn = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    run(0, 25);

    // relock at 160 then starve the input past the timeout
    push(1, 160, 3);
    push(2, 160, 3 + TO);
    tone_in = 1'b1;
    repeat (80) @(negedge clk);
    tone_in = 1'b0;
    repeat (TO + 10) @(negedge clk);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_period_held", int'(period), 160);

    run(0, 4);
    chk("locked_before_disable", int'(locked), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_locked", int'(locked), 0);
    chk("disable_period_held", int'(period), 160);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);

    run(0, 4);
    repeat (30) @(negedge clk);
    chk("locked_before_reset", int'(locked), 1);
    chk("scoreboard_drained", sbq.size(), 0);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_period", int'(period), 0);
    chk("async_reset_locked", int'(locked), 0);
    chk("async_reset_valid", int'(period_valid), 0);
    chk("async_reset_lost", int'(lost), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
